// File: rtl/cache_pkg.sv
// Shared constants, address field positions and FSM state type for the
// 2-way set-associative write-through cache controller.
package cache_pkg;

    localparam int SETS     = 64;
    localparam int TAG_W    = 10;
    localparam int IDX_W    = $clog2(SETS);
    localparam int WSEL_BIT = 2;
    localparam int IDX_LSB  = 3;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } cache_state_e;

    function automatic logic [31:0] sel_word(input logic [63:0] line, input logic sel);
        return sel ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage request bus and SRAM controller bus seen by cache_controller.
// slave = controller view, master = pipeline/SRAM view.
interface cache_controller_if;

    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport master (
        output address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

endinterface

// File: rtl/cache_storage.sv
// Tag/valid/data arrays for both ways plus one LRU bit per set.
// LRU bit names the way to evict next; valid and LRU clear on rst.
module cache_storage
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic             hit_way,
    output logic [63:0]      hit_line,
    output logic             victim_way,
    input  logic             fill_en,
    input  logic             fill_way,
    input  logic [63:0]      fill_line,
    input  logic             word_en,
    input  logic             word_sel,
    input  logic [31:0]      word_data,
    input  logic             touch_en,
    input  logic             touch_way
);

    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  valid_d [2];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [TAG_W-1:0] tag_d   [2][SETS];
    logic [63:0]      data_q  [2][SETS];
    logic [63:0]      data_d  [2][SETS];
    logic [SETS-1:0]  lru_q;
    logic [SETS-1:0]  lru_d;
    logic             hit0;
    logic             hit1;

    always_comb begin
        hit0       = valid_q[0][index] && (tag_q[0][index] == tag);
        hit1       = valid_q[1][index] && (tag_q[1][index] == tag);
        hit        = hit0 || hit1;
        hit_way    = hit1 && !hit0;
        hit_line   = hit_way ? data_q[1][index] : data_q[0][index];
        // Fill empty ways in order before falling back to the LRU choice.
        victim_way = !valid_q[0][index] ? 1'b0 :
                     !valid_q[1][index] ? 1'b1 : lru_q[index];
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        lru_d   = lru_q;
        if (fill_en) begin
            valid_d[fill_way][index] = 1'b1;
            tag_d[fill_way][index]   = tag;
            data_d[fill_way][index]  = fill_line;
        end
        if (word_en) begin
            if (word_sel) data_d[hit_way][index][63:32] = word_data;
            else          data_d[hit_way][index][31:0]  = word_data;
        end
        if (touch_en) lru_d[index] = ~touch_way;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '{default: '0};
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/cache_controller.sv
// MEM-stage cache controller: 2-way write-through, no-write-allocate cache
// with SRAM sequencing. Define CACHE_STATS_EN to add hit/miss counters.
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus,
    output cache_state_e       dbg_state
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    cache_state_e     state_q, state_d;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             hit, hit_way, victim_way;
    logic [63:0]      hit_line;
    logic             fill_en, word_en, touch_en, touch_way;

    assign index     = bus.address[IDX_LSB +: IDX_W];
    assign tag       = bus.address[TAG_LSB +: TAG_W];
    assign dbg_state = state_q;

    cache_storage u_storage (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .tag        (tag),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_line   (hit_line),
        .victim_way (victim_way),
        .fill_en    (fill_en),
        .fill_way   (victim_way),
        .fill_line  (bus.sram_rdata),
        .word_en    (word_en),
        .word_sel   (bus.address[WSEL_BIT]),
        .word_data  (bus.wdata),
        .touch_en   (touch_en),
        .touch_way  (touch_way)
    );

    // Handshake: ready=0 freezes the pipeline, which holds address/data/strobes
    // stable; sram_ready is a one-cycle completion pulse honoured only while busy.
    always_comb begin
        state_d          = state_q;
        bus.ready        = 1'b1;
        bus.rdata        = '0;
        bus.sram_r_en    = 1'b0;
        bus.sram_w_en    = 1'b0;
        bus.sram_address = '0;
        bus.sram_wdata   = '0;
        fill_en          = 1'b0;
        word_en          = 1'b0;
        touch_en         = 1'b0;
        touch_way        = hit_way;
        case (state_q)
            IDLE: begin
                if (bus.mem_w_en) begin
                    bus.ready = 1'b0;
                    state_d   = WRITE;
                end else if (bus.mem_r_en) begin
                    if (hit) begin
                        bus.rdata = sel_word(hit_line, bus.address[WSEL_BIT]);
                        touch_en  = 1'b1;
                    end else begin
                        bus.ready = 1'b0;
                        state_d   = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                bus.sram_r_en    = 1'b1;
                bus.sram_address = {bus.address[31:3], 3'b000};
                bus.ready        = 1'b0;
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    bus.rdata = sel_word(bus.sram_rdata, bus.address[WSEL_BIT]);
                    fill_en   = 1'b1;
                    touch_en  = 1'b1;
                    touch_way = victim_way;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                bus.sram_w_en    = 1'b1;
                bus.sram_address = bus.address;
                bus.sram_wdata   = bus.wdata;
                bus.ready        = 1'b0;
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    word_en   = hit;
                    touch_en  = hit;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && !bus.mem_w_en && bus.mem_r_en && hit)
            hit_count_d = hit_count_q + 32'd1;
        if (state_q == READ_MISS && bus.sram_ready)
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: recency-list cache model, SRAM responder
// with fixed latency, per-cycle output compare and literal load expectations.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int          LAT    = 3;
    localparam int          BUDGET = 50;
    localparam logic [63:0] JUNK   = 64'hBAD0_BAD1_BAD2_BAD3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_controller_if bus();
    cache_state_e       dbg_state;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic [31:0] line;
        logic [63:0] data;
    } line_t;

    line_t       cache_m[$];           // resident lines, most recently used first
    logic [63:0] sram_mem[logic [31:0]];
    logic [31:0] exp_q[$];             // literal load data, in request order
    int          n_checks = 0;
    int          n_fail   = 0;
    int          k        = 0;
    bit          txn_done = 0;
    bit          seen_rd, seen_wr;
    int          txn_cycles;
    logic [31:0] cap_addr, cap_wdata;
    logic        stray    = 1'b0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] line);
        return int'((line >> 3) % SETS);
    endfunction

    function automatic int find_line(input logic [31:0] line);
        foreach (cache_m[i]) if (cache_m[i].line == line) return i;
        return -1;
    endfunction

    task automatic touch(input int i);
        line_t e;
        e = cache_m[i];
        cache_m.delete(i);
        cache_m.push_front(e);
    endtask

    task automatic fill(input logic [31:0] line, input logic [63:0] data);
        line_t e;
        int    cnt = 0;
        foreach (cache_m[i]) if (set_of(cache_m[i].line) == set_of(line)) cnt++;
        if (cnt >= 2) begin
            for (int i = cache_m.size() - 1; i >= 0; i--) begin
                if (set_of(cache_m[i].line) == set_of(line)) begin
                    cache_m.delete(i);
                    break;
                end
            end
        end
        e.line = line;
        e.data = data;
        cache_m.push_front(e);
    endtask

    task automatic check_load(input logic [31:0] act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_literal: got %h with no expected value queued", act);
        end else begin
            check("load_literal", act, exp_q.pop_front());
        end
    endtask

    // SRAM responder: completion pulse on the LAT-th cycle of a held strobe.
    initial begin
        int cnt;
        cnt = 0;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = JUNK;
        forever begin
            @(posedge clk);
            #2;
            if (bus.sram_r_en || bus.sram_w_en) cnt++;
            else cnt = 0;
            if (cnt == LAT) begin
                bus.sram_ready = 1'b1;
                bus.sram_rdata = bus.sram_r_en ? sram_mem[bus.sram_address] : JUNK;
            end else begin
                bus.sram_ready = stray;
                bus.sram_rdata = JUNK;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] line;
        logic [63:0] ldata;
        line_t       e;
        int          idx;
        bit          done;
        line = bus.address & 32'hFFFF_FFF8;
        done = 1'b0;
        if (rst) begin
            k = 0;
            cache_m.delete();
            exp_hits   = 0;
            exp_misses = 0;
        end else if (!bus.mem_r_en && !bus.mem_w_en) begin
            check("idle_ready", bus.ready, 1);
            check("idle_rdata", bus.rdata, 0);
            check("idle_sram_r_en", bus.sram_r_en, 0);
            check("idle_sram_w_en", bus.sram_w_en, 0);
            check("idle_state", dbg_state, IDLE);
            k = 0;
        end else begin
            if (k == 0) begin
                seen_rd    = 1'b0;
                seen_wr    = 1'b0;
                txn_cycles = 0;
            end
            txn_cycles++;
            seen_rd = seen_rd | bus.sram_r_en;
            seen_wr = seen_wr | bus.sram_w_en;
            if (k == 0) begin
                check("req_sram_w_en", bus.sram_w_en, 0);
                check("req_sram_r_en", bus.sram_r_en, 0);
                if (bus.mem_w_en) begin
                    check("wr_first_ready", bus.ready, 0);
                end else begin
                    idx = find_line(line);
                    if (idx >= 0) begin
                        ldata = cache_m[idx].data;
                        check("hit_ready", bus.ready, 1);
                        check("hit_rdata", bus.rdata, sel_word(ldata, bus.address[2]));
                        touch(idx);
                        exp_hits++;
                        done = 1'b1;
                    end else begin
                        check("miss_first_ready", bus.ready, 0);
                    end
                end
            end else if (bus.mem_w_en) begin
                check("wr_sram_w_en", bus.sram_w_en, 1);
                check("wr_sram_r_en", bus.sram_r_en, 0);
                check("wr_sram_address", bus.sram_address, bus.address);
                check("wr_sram_wdata", bus.sram_wdata, bus.wdata);
                check("wr_ready", bus.ready, bus.sram_ready);
                if (bus.sram_ready) begin
                    ldata = sram_mem[line];
                    if (bus.address[2]) ldata[63:32] = bus.wdata;
                    else                ldata[31:0]  = bus.wdata;
                    sram_mem[line] = ldata;
                    idx = find_line(line);
                    if (idx >= 0) begin
                        e      = cache_m[idx];
                        e.data = ldata;
                        cache_m[idx] = e;
                        touch(idx);
                    end
                    done = 1'b1;
                end
            end else begin
                check("rm_sram_r_en", bus.sram_r_en, 1);
                check("rm_sram_w_en", bus.sram_w_en, 0);
                check("rm_sram_address", bus.sram_address, line);
                check("rm_ready", bus.ready, bus.sram_ready);
                if (bus.sram_ready) begin
                    ldata = sram_mem[line];
                    check("rm_rdata", bus.rdata, sel_word(ldata, bus.address[2]));
                    fill(line, ldata);
                    exp_misses++;
                    done = 1'b1;
                end
            end
            if (done) begin
                txn_done  = 1'b1;
                cap_addr  = bus.sram_address;
                cap_wdata = bus.sram_wdata;
                if (!bus.mem_w_en) check_load(bus.rdata);
                k = 0;
            end else begin
                k++;
            end
        end
    end

    task automatic do_req(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        bus.address  = a;
        bus.wdata    = d;
        bus.mem_w_en = is_wr;
        bus.mem_r_en = !is_wr;
        txn_done     = 1'b0;
        while (!txn_done && waited < BUDGET) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (!txn_done) begin
            n_fail++;
            $display("FAIL txn_timeout: addr %h not completed within %0d cycles", a, BUDGET);
        end
        #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                           input bit exp_miss, input int exp_cycles);
        exp_q.push_back(exp_data);
        do_req(1'b0, a, 32'h0);
        check("rd_sram_seen", seen_rd, exp_miss);
        check("rd_cycles", txn_cycles, exp_cycles);
        if (exp_miss) check("rd_line_addr", cap_addr, a & 32'hFFFF_FFF8);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        do_req(1'b1, a, d);
        check("wr_sram_seen", seen_wr, 1);
        check("wr_no_read", seen_rd, 0);
        check("wr_cycles", txn_cycles, 1 + LAT);
        check("wr_addr_lit", cap_addr, a);
        check("wr_data_lit", cap_wdata, d);
    endtask

    initial begin
        bus.address  = '0;
        bus.wdata    = '0;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        sram_mem[32'h400] = 64'hAAAA_AAAA_5555_5555;
        sram_mem[32'h600] = 64'h6666_6661_6666_6660;
        sram_mem[32'h800] = 64'h8888_8881_8888_8880;
        sram_mem[32'hA00] = 64'hA0A0_A0A1_A0A0_A0A0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready", bus.ready, 1);
        check("reset_rdata", bus.rdata, 0);
        check("reset_state", dbg_state, IDLE);
        check("reset_sram_r_en", bus.sram_r_en, 0);

        do_read(32'h400, 32'h5555_5555, 1, 1 + LAT);
        do_read(32'h400, 32'h5555_5555, 0, 1);
        do_read(32'h404, 32'hAAAA_AAAA, 0, 1);
        // Index 0 eviction: 0x600 becomes LRU once 0x400 is re-read.
        do_read(32'h600, 32'h6666_6660, 1, 1 + LAT);
        do_read(32'h400, 32'h5555_5555, 0, 1);
        do_read(32'h800, 32'h8888_8880, 1, 1 + LAT);
        do_read(32'h400, 32'h5555_5555, 0, 1);
        do_read(32'h600, 32'h6666_6660, 1, 1 + LAT);

        do_write(32'h404, 32'h1234_5678);
        do_read(32'h404, 32'h1234_5678, 0, 1);
        do_write(32'hA00, 32'hDEAD_BEEF);
        do_read(32'hA00, 32'hDEAD_BEEF, 1, 1 + LAT);

        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(posedge clk);
        #1;
        check("stray_state", dbg_state, IDLE);
        check("stray_sram_r_en", bus.sram_r_en, 0);
        do_read(32'h400, 32'h5555_5555, 0, 1);

        @(posedge clk);
        #1;
        bus.address  = 32'h600;
        bus.mem_r_en = 1'b1;
        @(posedge clk);
        #1;
        check("mid_state", dbg_state, READ_MISS);
        check("mid_sram_r_en", bus.sram_r_en, 1);
        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_state", dbg_state, IDLE);
        check("post_rst_sram_r_en", bus.sram_r_en, 0);
        check("post_rst_ready", bus.ready, 1);
        do_read(32'h400, 32'h5555_5555, 1, 1 + LAT);
        do_read(32'h404, 32'h1234_5678, 0, 1);

        @(posedge clk);
        #1;
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
`endif
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
